matmul_sequencer: RTL and testbench

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

---
 rtl/matmul_sequencer.sv | 160 ++++++++++++++++
 tb/tb_matmul_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/matmul_sequencer.sv
// Control sequencer for an NxN systolic matrix-multiply array.
// Drives the weight-load, stream and drain phases and flags each result row.
//
// Ports:
//   clk         - sole clock, rising edge
//   reset       - asynchronous active-high reset
//   enable      - global enable; low freezes the sequencer and masks strobes
//   start       - request one multiply, sampled only in IDLE
//   busy        - high in LOAD_W, STREAM and DRAIN
//   done        - one-cycle completion pulse
//   load_weight - weight-load strobe, w_addr selects the weight row
//   enable_mult - multiply/accumulate enable
//   data_valid  - input data present, d_addr selects the data row
//   out_valid   - a result row is present at the array output
//   out_row     - index of that result row
module matmul_sequencer #(
  parameter int MATRIX_SIZE   = 2,
  parameter int DATA_SIZE     = 32,
  parameter int ARRAY_LATENCY = 2 * MATRIX_SIZE - 1,
  localparam int AW = $clog2(MATRIX_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          load_weight,
  output logic          enable_mult,
  output logic          data_valid,
  output logic [AW-1:0] w_addr,
  output logic [AW-1:0] d_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_row
);

  // t must reach ARRAY_LATENCY+N-1
  localparam int TW = $clog2(ARRAY_LATENCY + MATRIX_SIZE);

  localparam logic [AW-1:0] K_LAST   = AW'(MATRIX_SIZE - 1);
  localparam logic [TW-1:0] T_SLAST  = TW'(MATRIX_SIZE - 1);
  localparam logic [TW-1:0] T_OFIRST = TW'(ARRAY_LATENCY);
  localparam logic [TW-1:0] T_LAST   =
    TW'(ARRAY_LATENCY + MATRIX_SIZE - 1);

  // The word width only matters to the datapath around this block.
  if (DATA_SIZE <= 0) begin : g_no_data
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [TW-1:0] t_q, t_d;

  logic          ov_raw;
  logic [TW-1:0] row_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
    end
  end

  // Enable low simply leaves state and counters where they are.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    if (enable) begin
      unique case (state_q)
        S_IDLE: begin
          k_d = '0;
          t_d = '0;
          if (start) state_d = S_LOAD_W;
        end
        S_LOAD_W: begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_STREAM;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        S_STREAM: begin
          t_d = t_q + 1'b1;
          if (t_q == T_SLAST) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (t_q == T_LAST) begin
            t_d     = '0;
            state_d = S_DONE;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign row_full = t_q - T_OFIRST;

  // Addresses decode from held state, so they hold through a stall
  // while the strobes are masked by enable.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    load_weight = 1'b0;
    enable_mult = 1'b0;
    data_valid  = 1'b0;
    w_addr      = '0;
    d_addr      = '0;
    ov_raw      = 1'b0;
    out_valid   = 1'b0;
    out_row     = '0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_LOAD_W: begin
        busy        = 1'b1;
        load_weight = enable;
        w_addr      = k_q;
      end
      S_STREAM: begin
        busy        = 1'b1;
        enable_mult = enable;
        data_valid  = enable;
        d_addr      = t_q[AW-1:0];
        ov_raw      = (t_q >= T_OFIRST) && (t_q <= T_LAST);
      end
      S_DRAIN: begin
        busy        = 1'b1;
        enable_mult = enable;
        ov_raw      = (t_q >= T_OFIRST) && (t_q <= T_LAST);
      end
      S_DONE: done = enable;
      default: begin
      end
    endcase
    if (ov_raw) begin
      out_valid = enable;
      out_row   = row_full[AW-1:0];
    end
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer at N=2 (L=3) and N=4 (L=7).
// Stimulus queues per-cycle expected outputs; a monitor checks them.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, st;
  logic busy, done, lw, em, dv, ov;
  logic [0:0] wa, da, orow;

  logic rst4, en4, st4;
  logic busy4, done4, lw4, em4, dv4, ov4;
  logic [1:0] wa4, da4, orow4;

  matmul_sequencer #(.MATRIX_SIZE(2)) dut2 (
    .clk(clk), .reset(rst), .enable(en), .start(st),
    .busy(busy), .done(done), .load_weight(lw),
    .enable_mult(em), .data_valid(dv),
    .w_addr(wa), .d_addr(da),
    .out_valid(ov), .out_row(orow)
  );

  matmul_sequencer #(.MATRIX_SIZE(4)) dut4 (
    .clk(clk), .reset(rst4), .enable(en4), .start(st4),
    .busy(busy4), .done(done4), .load_weight(lw4),
    .enable_mult(em4), .data_valid(dv4),
    .w_addr(wa4), .d_addr(da4),
    .out_valid(ov4), .out_row(orow4)
  );

  typedef struct {
    logic [11:0] v;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t  q2[$];
  exp_t  q4[$];
  exp_t  x2, x4;
  int    n_chk = 0;
  int    n_fail = 0;
  int    cnum = 0;
  string tag = "reset";

  localparam logic [11:0] Z = 12'h000;

  logic [11:0] act2, act4;
  assign act2 = {busy, done, lw, em, dv, 1'b0, wa,
                 1'b0, da, ov, 1'b0, orow};
  assign act4 = {busy4, done4, lw4, em4, dv4, wa4,
                 da4, ov4, orow4};

  // fields: busy done lw em dv w_addr d_addr out_valid out_row
  function automatic logic [11:0] ev(
    bit b, bit d, bit l, bit m, bit v,
    int w, int a, bit o, int r);
    return {b, d, l, m, v, w[1:0], a[1:0], o, r[1:0]};
  endfunction

  always @(negedge clk) begin
    if (q2.size() > 0) begin
      x2 = q2.pop_front();
      n_chk++;
      if (act2 !== x2.v) begin
        n_fail++;
        $display("FAIL n2 %s c%0d: got %b expected %b",
                 x2.tag, x2.cyc, act2, x2.v);
      end
    end
    if (q4.size() > 0) begin
      x4 = q4.pop_front();
      n_chk++;
      if (act4 !== x4.v) begin
        n_fail++;
        $display("FAIL n4 %s c%0d: got %b expected %b",
                 x4.tag, x4.cyc, act4, x4.v);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    cnum++;
  endtask

  task automatic cyc(bit s, bit e, bit r, logic [11:0] x);
    st  = s;
    en  = e;
    rst = r;
    q2.push_back('{x, cnum, tag});
    nxt();
  endtask

  task automatic cyc4(bit s, logic [11:0] x);
    st4 = s;
    q4.push_back('{x, cnum, tag});
    nxt();
  endtask

  task automatic begin_scen(string name);
    tag  = name;
    cnum = 0;
  endtask

  // Cycles 0..8 of an unstalled N=2 run; den gates the DONE cycle.
  task automatic nom(bit hs, bit den);
    cyc(1, 1, 0, Z);
    cyc(hs, 1, 0, ev(1, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(hs, 1, 0, ev(1, 0, 1, 0, 0, 1, 0, 0, 0));
    cyc(hs, 1, 0, ev(1, 0, 0, 1, 1, 0, 0, 0, 0));
    cyc(hs, 1, 0, ev(1, 0, 0, 1, 1, 0, 1, 0, 0));
    cyc(hs, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(hs, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 1, 0));
    cyc(hs, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 1, 1));
    cyc(hs, den, 0, den ? ev(0, 1, 0, 0, 0, 0, 0, 0, 0) : Z);
  endtask

  initial begin
    rst  = 1'b1; en  = 1'b1; st  = 1'b0;
    rst4 = 1'b1; en4 = 1'b1; st4 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      q2.push_back('{Z, i, "reset"});
      q4.push_back('{Z, i, "reset"});
      nxt();
    end
    rst4 = 1'b0;

    // release reset with start already high
    begin_scen("base");
    nom(0, 1);
    cyc(0, 1, 0, Z);

    begin_scen("stall");
    cyc(1, 1, 0, Z);
    cyc(0, 1, 0, ev(1, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 1, 0, 0, 1, 0, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 0, 1, 1, 0, 0, 0, 0));
    cyc(0, 0, 0, ev(1, 0, 0, 0, 0, 0, 1, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 0, 1, 1, 0, 1, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 1, 0));
    cyc(0, 1, 0, ev(1, 0, 0, 1, 0, 0, 0, 1, 1));
    cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, Z);

    begin_scen("done_stall");
    nom(0, 0);
    cyc(0, 1, 0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, Z);

    begin_scen("hold_start");
    nom(1, 1);
    nom(0, 1);
    cyc(0, 1, 0, Z);

    begin_scen("reset_mid");
    cyc(1, 1, 0, Z);
    cyc(0, 1, 0, ev(1, 0, 1, 0, 0, 0, 0, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 1, 0, 0, 1, 0, 0, 0));
    cyc(0, 1, 0, ev(1, 0, 0, 1, 1, 0, 0, 0, 0));
    cyc(0, 1, 1, Z);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, Z);

    begin_scen("n4");
    cyc4(1, Z);
    for (int k = 0; k < 4; k++)
      cyc4(0, ev(1, 0, 1, 0, 0, k, 0, 0, 0));
    for (int t = 0; t < 4; t++)
      cyc4(0, ev(1, 0, 0, 1, 1, 0, t, 0, 0));
    for (int t = 4; t < 7; t++)
      cyc4(0, ev(1, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int r = 0; r < 4; r++)
      cyc4(0, ev(1, 0, 0, 1, 0, 0, 0, 1, r));
    cyc4(0, ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc4(0, Z);

    for (int i = 0; i < 5; i++) begin
      if (q2.size() == 0 && q4.size() == 0) break;
      @(posedge clk);
    end
    n_chk++;
    if (q2.size() != 0 || q4.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0",
               q2.size(), q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
